// File: rtl/jag_arb_pkg.sv
// -----------------------------------------------------------------------------
// jag_arb_pkg
// Shared definitions for the co-processor bus arbiter.
//   REQ_*        : requester indices into the breq/back vectors
//   arb_state_t  : arbiter FSM state encoding (IDLE, GRANT, TURN)
//   req_onehot() : converts a requester index into a one-hot acknowledge
// -----------------------------------------------------------------------------
package jag_arb_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] REQ_CPU = 2'd0;
  localparam logic [1:0] REQ_GPU = 2'd1;
  localparam logic [1:0] REQ_DSP = 2'd2;
  localparam logic [1:0] REQ_DMA = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/dsp_bus_arb_if.sv
// -----------------------------------------------------------------------------
// dsp_bus_arb_if
// Request/acknowledge bundle between the bus requesters and the arbiter.
//   breq      : requests (0=CPU, 1=GPU, 2=DSP normal, 3=DSP high priority)
//   bus_busy  : a master cycle is outstanding
//   back      : one-hot bus acknowledge
//   owner     : index of the current owner, valid while owner_vld
//   owner_vld : a grant is active
//   revoke    : one-cycle pulse when a grant is withdrawn from a live request
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface dsp_bus_arb_if;
  logic [3:0] breq;
  logic       bus_busy;
  logic [3:0] back;
  logic [1:0] owner;
  logic       owner_vld;
  logic       revoke;

  modport master (
    output breq, bus_busy,
    input  back, owner, owner_vld, revoke
  );

  modport slave (
    input  breq, bus_busy,
    output back, owner, owner_vld, revoke
  );
endinterface

// File: rtl/arb_sat_counter.sv
// -----------------------------------------------------------------------------
// arb_sat_counter
// Saturating up-counter with synchronous clear.
//   clk, reset : clock and synchronous active-high reset
//   clr        : clear to zero (wins over inc)
//   inc        : count up by one, holding at LIMIT
//   count      : current value
// -----------------------------------------------------------------------------
module arb_sat_counter #(
  parameter int LIMIT = 64,
  parameter int WIDTH = $clog2(LIMIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != LIMIT_W)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dsp_bus_arb.sv
// -----------------------------------------------------------------------------
// dsp_bus_arb
// Shares the co-processor master bus between CPU, GPU, DSP normal and DSP
// high-priority requesters. Ownership changes only when no master cycle is
// outstanding; every handover passes through one dead TURN cycle.
//   clk, reset : clock and synchronous active-high reset
//   bus        : dsp_bus_arb_if.slave (breq/bus_busy in; back, owner,
//                owner_vld, revoke out, all registered)
// Parameters:
//   HOLD_MAX     : GRANT cycles before a non-DMA owner becomes revocable
//   CPU_WAIT_MAX : wait cycles after which the CPU outranks normal requesters
// -----------------------------------------------------------------------------
module dsp_bus_arb
  import jag_arb_pkg::*;
#(
  parameter int HOLD_MAX     = 64,
  parameter int CPU_WAIT_MAX = 256
) (
  input logic          clk,
  input logic          reset,
  dsp_bus_arb_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam int WAIT_W = $clog2(CPU_WAIT_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX_W     = HOLD_W'(HOLD_MAX);
  localparam logic [WAIT_W-1:0] CPU_WAIT_MAX_W = WAIT_W'(CPU_WAIT_MAX);

  arb_state_t   state_reg, state_next;
  logic [1:0]   owner_reg, owner_next;
  logic [3:0]   back_reg, back_next;
  logic         owner_vld_reg, owner_vld_next;
  logic         revoke_reg, revoke_next;
  logic         rr_dsp_reg, rr_dsp_next;   // 1: DSP has round-robin priority

  logic [HOLD_W-1:0] hold_cnt;
  logic [WAIT_W-1:0] cpu_wait_cnt;

  logic       arb_any;
  logic [1:0] arb_winner;
  logic       own_req;
  logic       release_cond;
  logic       preempt_cond;

  // hold_cnt is zero on the first GRANT cycle because it is held clear
  // in IDLE/TURN, then counts every GRANT cycle.
  arb_sat_counter #(.LIMIT(HOLD_MAX), .WIDTH(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state_reg != ST_GRANT),
    .inc   (state_reg == ST_GRANT),
    .count (hold_cnt)
  );

  arb_sat_counter #(.LIMIT(CPU_WAIT_MAX), .WIDTH(WAIT_W)) u_cpu_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!bus.breq[REQ_CPU] || back_reg[REQ_CPU]),
    .inc   (1'b1),
    .count (cpu_wait_cnt)
  );

  // Priority select used in IDLE and TURN.
  always_comb begin
    arb_any    = |bus.breq;
    arb_winner = REQ_CPU;
    if (bus.breq[REQ_DMA]) begin
      arb_winner = REQ_DMA;
    end else if (bus.breq[REQ_CPU] && (cpu_wait_cnt == CPU_WAIT_MAX_W)) begin
      arb_winner = REQ_CPU;
    end else if (bus.breq[REQ_GPU] && bus.breq[REQ_DSP]) begin
      arb_winner = rr_dsp_reg ? REQ_DSP : REQ_GPU;
    end else if (bus.breq[REQ_GPU]) begin
      arb_winner = REQ_GPU;
    end else if (bus.breq[REQ_DSP]) begin
      arb_winner = REQ_DSP;
    end
  end

  // Release and preemption are mutually exclusive through own_req, so a
  // dropping owner is always treated as a release without revoke.
  always_comb begin
    own_req      = bus.breq[owner_reg];
    release_cond = (state_reg == ST_GRANT) && !own_req && !bus.bus_busy;
    preempt_cond = (state_reg == ST_GRANT) && own_req && !bus.bus_busy &&
                   (owner_reg != REQ_DMA) &&
                   (bus.breq[REQ_DMA] ||
                    ((hold_cnt == HOLD_MAX_W) && |(bus.breq & ~back_reg)));
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_TURN: state_next = arb_any ? ST_GRANT : ST_IDLE;
      ST_GRANT:         state_next = (release_cond || preempt_cond) ? ST_TURN : ST_GRANT;
      default:          state_next = ST_IDLE;
    endcase
  end

  // Output logic: values loaded into the output registers.
  always_comb begin
    owner_next     = owner_reg;
    back_next      = back_reg;
    owner_vld_next = owner_vld_reg;
    revoke_next    = 1'b0;
    rr_dsp_next    = rr_dsp_reg;
    if ((state_reg != ST_GRANT) && (state_next == ST_GRANT)) begin
      owner_next     = arb_winner;
      back_next      = req_onehot(arb_winner);
      owner_vld_next = 1'b1;
      // Pointer moves past whichever normal requester was just served.
      if (arb_winner == REQ_GPU) rr_dsp_next = 1'b1;
      if (arb_winner == REQ_DSP) rr_dsp_next = 1'b0;
    end else if ((state_reg == ST_GRANT) && (state_next == ST_TURN)) begin
      back_next      = '0;
      owner_vld_next = 1'b0;
      revoke_next    = preempt_cond;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= REQ_CPU;
      back_reg      <= '0;
      owner_vld_reg <= 1'b0;
      revoke_reg    <= 1'b0;
      rr_dsp_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      back_reg      <= back_next;
      owner_vld_reg <= owner_vld_next;
      revoke_reg    <= revoke_next;
      rr_dsp_reg    <= rr_dsp_next;
    end
  end

  assign bus.back      = back_reg;
  assign bus.owner     = owner_reg;
  assign bus.owner_vld = owner_vld_reg;
  assign bus.revoke    = revoke_reg;

endmodule
